p4_hdr_programmer: RTL and testbench

// - AXI4-Lite initiator that programs the P4 header register block with one header config.
// - Accepts a config on a valid/ready handshake.
// - Issues nine 32-bit AXI-Lite writes to the header register map, in fixed order.
// - Reports completion with a sticky error flag.
// - Sits between a control-plane/config source and the header register slave on the same axil_aclk.

---
 rtl/p4_hdr_pkg.sv | 62 ++++++
 rtl/p4_axil_write_engine.sv | 76 +++++++
 rtl/p4_hdr_programmer.sv | 144 ++++++++++++++
 tb/tb_p4_hdr_programmer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/p4_hdr_pkg.sv
// Shared types, register offsets and the word-select helper for the P4 header programmer.
// The programmer walks word indices 0..P4_HDR_NWORDS-1 and asks word_sel() for each write.
package p4_hdr_pkg;

  localparam int P4_HDR_NWORDS = 9;
  localparam int IDX_W         = 4;
  localparam int OFS_W         = 12;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(P4_HDR_NWORDS - 1);

  localparam logic [OFS_W-1:0] REG_SMAC_LO = 12'h000;
  localparam logic [OFS_W-1:0] REG_SMAC_HI = 12'h004;
  localparam logic [OFS_W-1:0] REG_DMAC_LO = 12'h008;
  localparam logic [OFS_W-1:0] REG_DMAC_HI = 12'h00C;
  localparam logic [OFS_W-1:0] REG_SIP     = 12'h010;
  localparam logic [OFS_W-1:0] REG_DIP     = 12'h014;
  localparam logic [OFS_W-1:0] REG_SPORT   = 12'h018;
  localparam logic [OFS_W-1:0] REG_DPORT   = 12'h01C;
  localparam logic [OFS_W-1:0] REG_IPSUM   = 12'h020;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    RESP,
    DONE
  } prog_state_t;

  typedef struct packed {
    logic [47:0] smac;
    logic [47:0] dmac;
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sport;
    logic [15:0] dport;
    logic [15:0] ipsum;
  } hdr_cfg_t;

  typedef struct packed {
    logic [OFS_W-1:0] offset;
    logic [31:0]      data;
  } hdr_word_t;

  // Fixed write order of the header register map; upper halves are zero-padded.
  function automatic hdr_word_t word_sel(input logic [IDX_W-1:0] idx, input hdr_cfg_t cfg);
    hdr_word_t w;
    w.offset = REG_SMAC_LO;
    w.data   = cfg.smac[31:0];
    case (idx)
      4'd1: begin w.offset = REG_SMAC_HI; w.data = {16'h0000, cfg.smac[47:32]}; end
      4'd2: begin w.offset = REG_DMAC_LO; w.data = cfg.dmac[31:0];              end
      4'd3: begin w.offset = REG_DMAC_HI; w.data = {16'h0000, cfg.dmac[47:32]}; end
      4'd4: begin w.offset = REG_SIP;     w.data = cfg.sip;                     end
      4'd5: begin w.offset = REG_DIP;     w.data = cfg.dip;                     end
      4'd6: begin w.offset = REG_SPORT;   w.data = {16'h0000, cfg.sport};       end
      4'd7: begin w.offset = REG_DPORT;   w.data = {16'h0000, cfg.dport};       end
      4'd8: begin w.offset = REG_IPSUM;   w.data = {16'h0000, cfg.ipsum};       end
      default: ;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/p4_axil_write_engine.sv
// Single AXI4-Lite write: AW and W raised together on start, each dropped on its own
// handshake, then one B response is collected. At most one write is ever in flight.
module p4_axil_write_engine #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       data,
  output logic              idle,
  output logic              addr_done,
  output logic              done,
  output logic              err,
  output logic              awvalid,
  output logic [ADDR_W-1:0] awaddr,
  input  logic              awready,
  output logic              wvalid,
  output logic [31:0]       wdata,
  input  logic              wready,
  input  logic              bvalid,
  input  logic [1:0]        bresp,
  output logic              bready
);

  logic              aw_pend_reg;
  logic              w_pend_reg;
  logic              b_pend_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       data_reg;
  logic              aw_fire;
  logic              w_fire;

  assign aw_fire = aw_pend_reg & awready;
  assign w_fire  = w_pend_reg & wready;

  // True in the cycle the last outstanding of the AW/W handshakes completes.
  assign addr_done = (aw_pend_reg | w_pend_reg) &
                     (~aw_pend_reg | awready) &
                     (~w_pend_reg | wready);

  assign idle    = ~(aw_pend_reg | w_pend_reg | b_pend_reg);
  assign awvalid = aw_pend_reg;
  assign awaddr  = addr_reg;
  assign wvalid  = w_pend_reg;
  assign wdata   = data_reg;
  assign bready  = b_pend_reg;
  assign done    = b_pend_reg & bvalid;
  assign err     = done & (bresp != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_pend_reg <= 1'b0;
      w_pend_reg  <= 1'b0;
      b_pend_reg  <= 1'b0;
      addr_reg    <= '0;
      data_reg    <= '0;
    end else begin
      if (start) begin
        aw_pend_reg <= 1'b1;
        w_pend_reg  <= 1'b1;
        addr_reg    <= addr;
        data_reg    <= data;
      end else begin
        if (aw_fire) aw_pend_reg <= 1'b0;
        if (w_fire)  w_pend_reg  <= 1'b0;
      end
      if (addr_done) begin
        b_pend_reg <= 1'b1;
      end else if (done) begin
        b_pend_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/p4_hdr_programmer.sv
// Accepts one header config and programs it into the header register block as nine
// AXI4-Lite writes in fixed order, reporting completion with a sticky error flag.
module p4_hdr_programmer
  import p4_hdr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ADDR_W    = 32
) (
  input  logic              axil_aclk,
  input  logic              axil_aresetn,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [47:0]       cfg_smac,
  input  logic [47:0]       cfg_dmac,
  input  logic [31:0]       cfg_sip,
  input  logic [31:0]       cfg_dip,
  input  logic [15:0]       cfg_sport,
  input  logic [15:0]       cfg_dport,
  input  logic [15:0]       cfg_ipsum,
  output logic              busy,
  output logic              done_valid,
  output logic              done_err,
  output logic              m_axil_awvalid,
  output logic [ADDR_W-1:0] m_axil_awaddr,
  input  logic              m_axil_awready,
  output logic              m_axil_wvalid,
  output logic [31:0]       m_axil_wdata,
  output logic [3:0]        m_axil_wstrb,
  input  logic              m_axil_wready,
  input  logic              m_axil_bvalid,
  input  logic [1:0]        m_axil_bresp,
  output logic              m_axil_bready,
  output logic              m_axil_arvalid,
  output logic [ADDR_W-1:0] m_axil_araddr,
  output logic              m_axil_rready
);

  prog_state_t       state_reg;
  prog_state_t       state_next;
  logic [IDX_W-1:0]  idx_reg;
  logic              err_reg;
  hdr_cfg_t          cfg_reg;
  hdr_cfg_t          cfg_in;
  hdr_word_t         word;
  logic [ADDR_W-1:0] eng_addr;
  logic              eng_start;
  logic              eng_idle;
  logic              eng_addr_done;
  logic              eng_done;
  logic              eng_err;
  logic              accept;

  assign cfg_in   = {cfg_smac, cfg_dmac, cfg_sip, cfg_dip, cfg_sport, cfg_dport, cfg_ipsum};
  assign accept   = cfg_valid & cfg_ready;
  assign word     = word_sel(idx_reg, cfg_reg);
  assign eng_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(word.offset);

  always_ff @(posedge axil_aclk) begin
    if (!axil_aresetn) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (cfg_valid) state_next = ADDR;
      ADDR: if (eng_addr_done) state_next = RESP;
      RESP: if (eng_done) state_next = (idx_reg == LAST_IDX) ? DONE : ADDR;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The engine is kicked once per ADDR visit: it is idle only in the first ADDR cycle.
  always_comb begin
    cfg_ready  = 1'b0;
    busy       = 1'b0;
    done_valid = 1'b0;
    done_err   = 1'b0;
    eng_start  = 1'b0;
    case (state_reg)
      IDLE: cfg_ready = 1'b1;
      ADDR: begin
        busy      = 1'b1;
        eng_start = eng_idle;
      end
      RESP: busy = 1'b1;
      DONE: begin
        done_valid = 1'b1;
        done_err   = err_reg;
      end
      default: ;
    endcase
  end

  always_ff @(posedge axil_aclk) begin
    if (!axil_aresetn) begin
      idx_reg <= '0;
      err_reg <= 1'b0;
      cfg_reg <= '0;
    end else begin
      if (accept) begin
        cfg_reg <= cfg_in;
        idx_reg <= '0;
        err_reg <= 1'b0;
      end else if (state_reg == RESP && eng_done) begin
        err_reg <= err_reg | eng_err;
        if (idx_reg != LAST_IDX) idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  p4_axil_write_engine #(
    .ADDR_W (ADDR_W)
  ) eng (
    .clk       (axil_aclk),
    .rst_n     (axil_aresetn),
    .start     (eng_start),
    .addr      (eng_addr),
    .data      (word.data),
    .idle      (eng_idle),
    .addr_done (eng_addr_done),
    .done      (eng_done),
    .err       (eng_err),
    .awvalid   (m_axil_awvalid),
    .awaddr    (m_axil_awaddr),
    .awready   (m_axil_awready),
    .wvalid    (m_axil_wvalid),
    .wdata     (m_axil_wdata),
    .wready    (m_axil_wready),
    .bvalid    (m_axil_bvalid),
    .bresp     (m_axil_bresp),
    .bready    (m_axil_bready)
  );

  assign m_axil_wstrb   = 4'hF;
  assign m_axil_arvalid = 1'b0;
  assign m_axil_araddr  = '0;
  assign m_axil_rready  = 1'b1;

endmodule

// File: tb/tb_p4_hdr_programmer.sv
// Directed bench: behavioural AXI-Lite slave with ready delays and error injection,
// driving full programming sequences and checking order, data, latency and reset abort.
module tb_p4_hdr_programmer;

  localparam logic [31:0] BASE = 32'h4000_1000;

  logic        clk = 1'b0;
  logic        aresetn;
  logic        cfg_valid, cfg_ready;
  logic [47:0] cfg_smac, cfg_dmac;
  logic [31:0] cfg_sip, cfg_dip;
  logic [15:0] cfg_sport, cfg_dport, cfg_ipsum;
  logic        busy, done_valid, done_err;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata;
  logic [3:0]  wstrb;
  logic [1:0]  bresp;
  logic        arvalid, rready;
  logic [31:0] araddr;

  always #5 clk = ~clk;

  p4_hdr_programmer #(.BASE_ADDR(BASE), .ADDR_W(32)) dut (
    .axil_aclk(clk), .axil_aresetn(aresetn),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_smac(cfg_smac), .cfg_dmac(cfg_dmac), .cfg_sip(cfg_sip), .cfg_dip(cfg_dip),
    .cfg_sport(cfg_sport), .cfg_dport(cfg_dport), .cfg_ipsum(cfg_ipsum),
    .busy(busy), .done_valid(done_valid), .done_err(done_err),
    .m_axil_awvalid(awvalid), .m_axil_awaddr(awaddr), .m_axil_awready(awready),
    .m_axil_wvalid(wvalid), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb), .m_axil_wready(wready),
    .m_axil_bvalid(bvalid), .m_axil_bresp(bresp), .m_axil_bready(bready),
    .m_axil_arvalid(arvalid), .m_axil_araddr(araddr), .m_axil_rready(rready)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int aw_dly = 0, w_dly = 0, err_at = -1;
  int aw_cnt = 0, w_cnt = 0;
  bit got_aw = 0, got_w = 0;
  logic [31:0] cur_addr, cur_data;
  logic [31:0] log_addr [0:127];
  logic [31:0] log_data [0:127];
  logic [31:0] regs [0:15];
  int wr_total = 0, aw_hs = 0, w_hs = 0, b_hs = 0, strb_bad = 0;

  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid && (w_cnt >= w_dly);

  always @(posedge clk) begin
    int ri;
    if (!aresetn) begin
      bvalid <= 1'b0;
      bresp  <= 2'b00;
      got_aw = 0; got_w = 0; aw_cnt = 0; w_cnt = 0;
    end else begin
      if (bvalid && bready) begin
        bvalid <= 1'b0;
        b_hs++;
      end
      if (awvalid && awready) begin
        got_aw = 1; cur_addr = awaddr; aw_cnt = 0; aw_hs++;
      end else if (awvalid) aw_cnt++;
      if (wvalid && wready) begin
        got_w = 1; cur_data = wdata; w_cnt = 0; w_hs++;
        if (wstrb != 4'hF) strb_bad++;
      end else if (wvalid) w_cnt++;
      if (got_aw && got_w) begin
        if (wr_total < 128) begin
          log_addr[wr_total] = cur_addr;
          log_data[wr_total] = cur_data;
        end
        ri = int'((cur_addr - BASE) >> 2);
        if (ri >= 0 && ri < 16) regs[ri] = cur_data;
        bresp  <= (wr_total == err_at) ? 2'b10 : 2'b00;
        bvalid <= 1'b1;
        $display("write %0d addr=%08h data=%08h", wr_total, cur_addr, cur_data);
        wr_total++;
        got_aw = 0; got_w = 0;
      end
    end
  end

  // ---------------- monitor ----------------
  int cyc = 0, acc_cyc = 0, done_cyc = 0, accept_count = 0, done_count = 0;
  int aw_only = 0, ready_busy = 0, stab_viol = 0;
  bit aw_hold = 0, w_hold = 0;
  logic [31:0] aw_hold_addr, w_hold_data;

  always @(posedge clk) begin
    if (aresetn) begin
      if (cfg_valid && cfg_ready) begin accept_count++; acc_cyc = cyc; end
      if (done_valid) begin done_count++; done_cyc = cyc; end
      if (awvalid && !wvalid) aw_only++;
      if (busy && cfg_ready) ready_busy++;
      if (aw_hold && (!awvalid || awaddr != aw_hold_addr)) stab_viol++;
      if (w_hold && (!wvalid || wdata != w_hold_data)) stab_viol++;
      aw_hold = awvalid && !awready; aw_hold_addr = awaddr;
      w_hold  = wvalid && !wready;   w_hold_data  = wdata;
    end else begin
      aw_hold = 0; w_hold = 0;
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  logic [47:0] ex_smac, ex_dmac;
  logic [31:0] ex_sip, ex_dip;
  logic [15:0] ex_sport, ex_dport, ex_ipsum;
  bit last_err;

  task automatic send(input logic [47:0] smac, input logic [47:0] dmac, input logic [31:0] sip,
                      input logic [31:0] dip, input logic [15:0] sport, input logic [15:0] dport,
                      input logic [15:0] ipsum, input bit hold);
    int start = accept_count;
    int n = 0;
    @(negedge clk);
    cfg_smac = smac; cfg_dmac = dmac; cfg_sip = sip; cfg_dip = dip;
    cfg_sport = sport; cfg_dport = dport; cfg_ipsum = ipsum;
    ex_smac = smac; ex_dmac = dmac; ex_sip = sip; ex_dip = dip;
    ex_sport = sport; ex_dport = dport; ex_ipsum = ipsum;
    cfg_valid = 1'b1;
    while (accept_count == start && n < 50) begin @(negedge clk); n++; end
    check("accept_seen", 64'(accept_count != start), 64'd1);
    if (hold) begin
      cfg_smac = ~smac; cfg_dmac = ~dmac; cfg_sip = ~sip; cfg_dip = ~dip;
      cfg_sport = ~sport; cfg_dport = ~dport; cfg_ipsum = ~ipsum;
    end else begin
      cfg_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    bit seen = 0;
    while (!seen && n < budget) begin
      @(negedge clk); n++;
      if (done_valid) begin
        seen = 1; last_err = done_err; cfg_valid = 1'b0;
      end
    end
    check("done_seen", 64'(seen), 64'd1);
    @(posedge clk); #1;
    $display("sequence done latency=%0d err=%0d", done_cyc - acc_cyc, last_err);
  endtask

  task automatic check_regs();
    check("rb_smac_lo", regs[0], ex_smac[31:0]);
    check("rb_smac_hi", regs[1], {16'h0, ex_smac[47:32]});
    check("rb_dmac_lo", regs[2], ex_dmac[31:0]);
    check("rb_dmac_hi", regs[3], {16'h0, ex_dmac[47:32]});
    check("rb_sip",     regs[4], ex_sip);
    check("rb_dip",     regs[5], ex_dip);
    check("rb_sport",   regs[6], {16'h0, ex_sport});
    check("rb_dport",   regs[7], {16'h0, ex_dport});
    check("rb_ipsum",   regs[8], {16'h0, ex_ipsum});
  endtask

  logic [31:0] exp_a1 [0:8] = '{32'h4000_1000, 32'h4000_1004, 32'h4000_1008, 32'h4000_100C,
                                32'h4000_1010, 32'h4000_1014, 32'h4000_1018, 32'h4000_101C,
                                32'h4000_1020};
  logic [31:0] exp_d1 [0:8] = '{32'h0C0D_0E0F, 32'h0000_0A0B, 32'h3344_5566, 32'h0000_1122,
                                32'hC0A8_0001, 32'hC0A8_0002, 32'h0000_1234, 32'h0000_5678,
                                32'h0000_BEEF};

  initial begin
    int base, b0, awo0, aw0, w0, acc0, rb0, dc0, n;
    aresetn = 1'b0; cfg_valid = 1'b0;
    cfg_smac = '0; cfg_dmac = '0; cfg_sip = '0; cfg_dip = '0;
    cfg_sport = '0; cfg_dport = '0; cfg_ipsum = '0;
    for (int i = 0; i < 16; i++) regs[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_rready", rready, 1);
    check("rst_awvalid", awvalid, 0);
    check("rst_wvalid", wvalid, 0);
    check("rst_bready", bready, 0);
    check("rst_busy", busy, 0);
    check("rst_done_valid", done_valid, 0);
    check("rst_done_err", done_err, 0);
    check("rst_arvalid", arvalid, 0);
    aresetn = 1'b1;

    // all ready, minimum latency
    base = wr_total; b0 = b_hs;
    send(48'h0A0B_0C0D_0E0F, 48'h1122_3344_5566, 32'hC0A8_0001, 32'hC0A8_0002,
         16'h1234, 16'h5678, 16'hBEEF, 0);
    wait_done(200);
    check("t1_latency", 64'(done_cyc - acc_cyc), 64'd28);
    check("t1_done_err", 64'(last_err), 64'd0);
    check("t1_nwrites", 64'(wr_total - base), 64'd9);
    check("t1_nb", 64'(b_hs - b0), 64'd9);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("t1_addr%0d", i), log_addr[base+i], exp_a1[i]);
      check($sformatf("t1_data%0d", i), log_data[base+i], exp_d1[i]);
    end
    check_regs();

    // awready delayed 5 cycles, wready immediate
    @(negedge clk); aw_dly = 5;
    base = wr_total; b0 = b_hs; awo0 = aw_only; aw0 = aw_hs; w0 = w_hs;
    send(48'hDEAD_BEEF_0001, 48'h0200_0000_00FE, 32'h0A00_0001, 32'h0A00_00FE,
         16'h0050, 16'hC350, 16'h1A2B, 0);
    wait_done(400);
    check("t2_latency", 64'(done_cyc - acc_cyc), 64'd73);
    check("t2_aw_only_cycles", 64'(aw_only - awo0), 64'd45);
    check("t2_nwrites", 64'(wr_total - base), 64'd9);
    check("t2_aw_hs", 64'(aw_hs - aw0), 64'd9);
    check("t2_w_hs", 64'(w_hs - w0), 64'd9);
    check("t2_nb", 64'(b_hs - b0), 64'd9);
    check("t2_done_err", 64'(last_err), 64'd0);
    check_regs();

    // SLVERR on write 4 only
    @(negedge clk); aw_dly = 0; base = wr_total; err_at = wr_total + 4;
    send(48'h0102_0304_0506, 48'h0708_090A_0B0C, 32'h1111_2222, 32'h3333_4444,
         16'h5555, 16'h6666, 16'h7777, 0);
    wait_done(200);
    check("t3_nwrites", 64'(wr_total - base), 64'd9);
    check("t3_last_addr", log_addr[base+8], 64'h4000_1020);
    check("t3_done_err", 64'(last_err), 64'd1);
    @(negedge clk); err_at = -1;
    send(48'hAABB_CCDD_EEFF, 48'h1020_3040_5060, 32'h0101_0101, 32'h0202_0202,
         16'h0303, 16'h0404, 16'h0505, 0);
    wait_done(200);
    check("t3b_done_err", 64'(last_err), 64'd0);

    // cfg_valid held with changed fields while busy
    acc0 = accept_count; rb0 = ready_busy;
    send(48'h5A5A_1234_A5A5, 48'h0F0F_5678_F0F0, 32'hAC10_0001, 32'hAC10_0002,
         16'h1F90, 16'h01BB, 16'hFACE, 1);
    wait_done(200);
    check("t4_accepts", 64'(accept_count - acc0), 64'd1);
    check("t4_ready_while_busy", 64'(ready_busy - rb0), 64'd0);
    check_regs();

    // reset during RESP of write 3
    base = wr_total; dc0 = done_count; n = 0;
    send(48'h9999_8888_7777, 48'h6666_5555_4444, 32'h3333_3333, 32'h2222_2222,
         16'h1111, 16'h0000, 16'hFFFF, 0);
    while (!(bready && (wr_total - base) == 4) && n < 200) begin @(negedge clk); n++; end
    check("t5_reached_resp3", 64'(bready && (wr_total - base) == 4), 64'd1);
    aresetn = 1'b0;
    @(negedge clk);
    check("t5_awvalid", awvalid, 0);
    check("t5_wvalid", wvalid, 0);
    check("t5_bready", bready, 0);
    check("t5_busy", busy, 0);
    check("t5_cfg_ready", cfg_ready, 1);
    aresetn = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_no_done", 64'(done_count - dc0), 64'd0);
    base = wr_total;
    send(48'h0000_1111_2222, 48'h3333_4444_5555, 32'h6666_7777, 32'h8888_9999,
         16'hAAAA, 16'hBBBB, 16'hCCCC, 0);
    wait_done(200);
    check("t5_restart_addr", log_addr[base], BASE);
    check("t5_nwrites", 64'(wr_total - base), 64'd9);
    check("t5_done_err", 64'(last_err), 64'd0);
    check_regs();

    check("stability_violations", 64'(stab_viol), 64'd0);
    check("wstrb_bad", 64'(strb_bad), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
